// File: rtl/lc3_ram_ws.sv
`default_nettype none
// ============================================================================
// Module   : lc3_ram_ws
// Purpose  : Single-port word RAM with a configurable number of wait states
//            per access and an optional zero-fill sweep after reset.
//            A requester raises cs and holds it; the request is captured on
//            the first edge it is seen in IDLE, and ready pulses for one
//            cycle WAIT_STATES edges later. A mandatory DONE cycle follows
//            every access, so back-to-back requests are at least two cycles
//            apart.
// Ports    : clk      - clock, rising edge
//            rst_n    - synchronous active-low reset
//            cs       - request strobe
//            r_w      - 1 = write, 0 = read
//            data_in  - write data
//            addr     - word address
//            ready    - one-cycle completion pulse
//            data_out - registered read data, held until the next read
// Revision : 1.0 - initial release
// ============================================================================
module lc3_ram_ws #(
  parameter  int DATA_WIDTH     = 16,
  parameter  int DEPTH          = 65024,
  parameter  int WAIT_STATES    = 2,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int ADDR_WIDTH     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  r_w,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   C_DEPTH     = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]            C_WAITS     = 4'(WAIT_STATES);

  logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];

  logic [1:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q,  clr_cnt_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic                  req_rw_q,   req_rw_d;
  logic                  ready_q,    ready_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  // Access strobe and the fields that govern it. With zero wait states the
  // access happens on the capture edge itself, so the live inputs are used
  // because the latched copies are not yet valid.
  logic                  w_acc;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [DATA_WIDTH-1:0] w_acc_data;
  logic                  w_acc_rw;
  logic                  w_acc_in_range;
  logic                  w_clr_we;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_wa;
  logic [DATA_WIDTH-1:0] w_ram_wd;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_rw_d   = req_rw_q;
    ready_d    = ready_q;
    w_acc      = 1'b0;
    w_acc_addr = req_addr_q;
    w_acc_data = req_data_q;
    w_acc_rw   = req_rw_q;
    w_clr_we   = 1'b0;

    case (state_q)
      S_CLEAR: begin
        w_clr_we = 1'b1;
        ready_d  = 1'b0;
        if (clr_cnt_q == C_LAST_ADDR) begin
          state_d = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (cs) begin
          req_addr_d = addr;
          req_data_d = data_in;
          req_rw_d   = r_w;
          wait_cnt_d = C_WAITS;
          if (WAIT_STATES == 0) begin
            w_acc      = 1'b1;
            w_acc_addr = addr;
            w_acc_data = data_in;
            w_acc_rw   = r_w;
            ready_d    = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd1) begin
          w_acc   = 1'b1;
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: begin
        // DONE: cs is deliberately ignored here to force an idle gap.
        ready_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Addresses beyond DEPTH are legal requests that touch nothing.
  assign w_acc_in_range = ({1'b0, w_acc_addr} < C_DEPTH);

  always_comb begin
    data_out_d = data_out_q;
    if (w_acc && !w_acc_rw) begin
      data_out_d = w_acc_in_range ? ram[w_acc_addr] : '0;
    end
  end

  // Reset has priority over any write so an aborted request leaves the
  // array untouched.
  assign w_ram_we = rst_n && (w_clr_we || (w_acc && w_acc_rw && w_acc_in_range));
  assign w_ram_wa = w_clr_we ? clr_cnt_q : w_acc_addr;
  assign w_ram_wd = w_clr_we ? '0 : w_acc_data;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      ram[w_ram_wa] <= w_ram_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clr_cnt_q  <= '0;
      wait_cnt_q <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_rw_q   <= 1'b0;
      ready_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_rw_q   <= req_rw_d;
      ready_q    <= ready_d;
      data_out_q <= data_out_d;
    end
  end

  assign ready    = ready_q;
  assign data_out = data_out_q;

endmodule
`default_nettype wire
